// File: rtl/aes_req_scheduler.sv
// rtl/aes_req_scheduler.sv - two-requester round-robin front end for a shared AES_top core
module aes_req_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         core_en,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key_in,
  input  logic [127:0] core_data_out,
  input  logic         core_data_out_valid,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_timeout,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP, S_GAP} state_t;

  state_t     state, state_nxt;
  logic       ptr;
  logic [7:0] cnt;
  logic       grant_any, grant_id, accept;
  logic       run_timeout, gap_done, rsp_ack;

  // ptr = 0 favours requester 0 when both are valid
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ptr : req1_valid;
  end

  assign accept      = (state == S_IDLE) && grant_any;
  assign run_timeout = (cnt == 8'(TIMEOUT_CYCLES - 1));
  assign gap_done    = (cnt == 8'(GAP_CYCLES - 1));
  assign rsp_ack     = (state == S_RESP) && rsp_ready;

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_RUN;
      S_RUN:  if (core_data_out_valid || run_timeout) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_GAP;
      S_GAP:  if (gap_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    core_en    = (state == S_RUN);
    rsp_valid  = (state == S_RESP);
    busy       = (state != S_IDLE);
    req0_ready = (state == S_IDLE) && grant_any && !grant_id;
    req1_ready = (state == S_IDLE) && grant_any && grant_id;
  end

  // Job datapath; cnt counts RUN cycles, then is reused for the GAP length
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      ptr          <= 1'b0;
      cnt          <= 8'd0;
      core_data_in <= 128'd0;
      core_key_in  <= 128'd0;
      rsp_id       <= 1'b0;
      rsp_data     <= 128'd0;
      rsp_timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            core_data_in <= grant_id ? req1_data : req0_data;
            core_key_in  <= grant_id ? req1_key : req0_key;
            rsp_id       <= grant_id;
            ptr          <= ~grant_id;
            cnt          <= 8'd0;
          end
        end
        S_RUN: begin
          cnt <= cnt + 8'd1;
          if (core_data_out_valid) begin
            rsp_data    <= core_data_out;
            rsp_timeout <= 1'b0;
          end else if (run_timeout) begin
            rsp_data    <= 128'd0;
            rsp_timeout <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ack) cnt <= 8'd0;
        end
        S_GAP: begin
          cnt <= cnt + 8'd1;
        end
        default: cnt <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// tb/tb_aes_req_scheduler.sv - directed bench for aes_req_scheduler with a stub AES core
module tb_aes_req_scheduler;

  localparam int LAT = 5;
  localparam int TO  = 64;
  localparam int GAP = 2;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CKEY     = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;

  logic         AES_clk = 1'b0;
  logic         AES_rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_data = '0, req0_key = '0, req1_data = '0, req1_key = '0;
  logic         core_en;
  logic [127:0] core_data_in, core_key_in, core_data_out;
  logic         core_data_out_valid;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_timeout, busy;
  logic [127:0] rsp_data;

  logic [7:0]   lat_cnt = 8'd0;
  logic         stub_hang = 1'b0, stray = 1'b0;

  int nvec = 0;
  int nmis = 0;

  always #5 AES_clk = ~AES_clk;

  aes_req_scheduler #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .AES_clk(AES_clk), .AES_rst(AES_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .core_en(core_en), .core_data_in(core_data_in), .core_key_in(core_key_in),
    .core_data_out(core_data_out), .core_data_out_valid(core_data_out_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  // Stub core: answers LAT cycles after AES_en rises; FIPS vector is exact, others return data^key
  always @(posedge AES_clk) lat_cnt <= core_en ? lat_cnt + 8'd1 : 8'd0;
  assign core_data_out_valid = (core_en && !stub_hang && lat_cnt == 8'(LAT - 1)) || stray;
  assign core_data_out = (core_data_in == FIPS_PT && core_key_in == FIPS_KEY) ? FIPS_CT
                                                                              : (core_data_in ^ core_key_in);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge AES_clk);
    #1;
  endtask

  // Counts core_en-high cycles from the current one until rsp_valid appears
  task automatic wait_rsp(output int n_en);
    int guard;
    n_en = 0;
    guard = 0;
    while (!rsp_valid && guard < 300) begin
      if (core_en) n_en++;
      guard++;
      step();
    end
    check("rsp_wait", rsp_valid, 1'b1);
  endtask

  // Counts busy cycles after the response handshake until IDLE
  task automatic wait_gap(output int g);
    int guard;
    g = 0;
    guard = 0;
    while (busy && guard < 50) begin
      if (core_en) check("gap_core_en", core_en, 1'b0);
      g++;
      guard++;
      step();
    end
  endtask

  task automatic run_job(input logic id, input logic [127:0] d, input logic [127:0] k);
    int n;
    int g;
    step();
    if (id) begin req1_valid = 1'b1; req1_data = d; req1_key = k; end
    else    begin req0_valid = 1'b1; req0_data = d; req0_key = k; end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(n);
    check("job_data", rsp_data, d ^ k);
    step();
    wait_gap(g);
  endtask

  logic [127:0] d0 [3];
  logic [127:0] d1 [3];

  initial begin
    int n, g, j0, j1, nr, guard, bad;
    logic pend0, pend1, exp_id;
    logic [127:0] exp_d;

    d0[0] = 128'h00000024000000000000000000000000;
    d0[1] = 128'h00000024000000000000000000000001;
    d0[2] = 128'h00000024000000000000000000000002;
    d1[0] = 128'ha6f2daeb140fa720529e75d521cbc681;
    d1[1] = 128'ha6f2daeb140fa720529e75d521cbc682;
    d1[2] = 128'ha6f2daeb140fa720529e75d521cbc683;

    // Reset state
    step();
    check("rst_core_en", core_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_core_data_in", core_data_in, 128'd0);
    check("rst_rsp_data", rsp_data, 128'd0);
    AES_rst = 1'b0;

    // Single FIPS-197 job
    step();
    req0_valid = 1'b1; req0_data = FIPS_PT; req0_key = FIPS_KEY;
    #1;
    check("fips_req0_ready", req0_ready, 1'b1);
    check("fips_req1_ready", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0; req0_data = '0; req0_key = '0;
    #1;
    check("fips_ready_one_cycle", req0_ready, 1'b0);
    check("fips_core_en_next", core_en, 1'b1);
    check("fips_core_data_in", core_data_in, FIPS_PT);
    wait_rsp(n);
    check("fips_en_cycles", n, LAT);
    check("fips_core_en_resp", core_en, 1'b0);
    check("fips_rsp_id", rsp_id, 1'b0);
    check("fips_rsp_timeout", rsp_timeout, 1'b0);
    check("fips_rsp_data", rsp_data, FIPS_CT);
    step();
    check("fips_rsp_drop", rsp_valid, 1'b0);
    wait_gap(g);
    check("fips_gap_len", g, GAP);

    // Backpressure with both requesters waiting
    rsp_ready = 1'b0;
    step();
    req1_valid = 1'b1; req1_data = d1[0]; req1_key = CKEY;
    step();
    req1_valid = 1'b0;
    wait_rsp(n);
    req0_valid = 1'b1; req1_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!rsp_valid || rsp_id !== 1'b1 || rsp_data !== (d1[0] ^ CKEY) ||
          req0_ready || req1_ready || core_en) bad++;
    end
    check("bp_stable_cycles_bad", bad, 0);
    check("bp_rsp_data", rsp_data, d1[0] ^ CKEY);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    wait_gap(g);

    // Watchdog timeout; req1 waits and is granted right after the gap
    stub_hang = 1'b1;
    step();
    req0_valid = 1'b1; req0_data = FIPS_PT; req0_key = CKEY;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = d1[1]; req1_key = CKEY;
    wait_rsp(n);
    check("to_en_cycles", n, TO);
    check("to_rsp_timeout", rsp_timeout, 1'b1);
    check("to_rsp_data", rsp_data, 128'd0);
    check("to_rsp_id", rsp_id, 1'b0);
    check("to_req1_blocked", req1_ready, 1'b0);
    stub_hang = 1'b0;
    step();
    wait_gap(g);
    check("to_gap_len", g, GAP);
    check("to_next_grant", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    wait_rsp(n);
    check("to_next_data", rsp_data, d1[1] ^ CKEY);
    check("to_next_timeout", rsp_timeout, 1'b0);
    step();
    wait_gap(g);

    // Reset mid-RUN after a req0 grant (pointer would otherwise favour req1)
    stub_hang = 1'b1;
    step();
    req0_valid = 1'b1; req0_data = d0[0]; req0_key = CKEY;
    step();
    req0_valid = 1'b0;
    repeat (9) step();
    check("mr_in_run", core_en, 1'b1);
    #2 AES_rst = 1'b1;
    #1;
    check("mr_core_en", core_en, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_rsp_valid", rsp_valid, 1'b0);
    step();
    AES_rst = 1'b0;
    stub_hang = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid) bad++;
    end
    check("mr_no_rsp", bad, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mr_req0_wins", req0_ready, 1'b1);
    check("mr_req1_loses", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Stray core valid in IDLE and in GAP
    stray = 1'b1;
    step();
    stray = 1'b0;
    check("stray_idle_busy", busy, 1'b0);
    check("stray_idle_rsp", rsp_valid, 1'b0);
    step();
    req0_valid = 1'b1; req0_data = d0[1]; req0_key = CKEY;
    step();
    req0_valid = 1'b0;
    wait_rsp(n);
    step();
    stray = 1'b1;
    step();
    stray = 1'b0;
    check("stray_gap_rsp", rsp_valid, 1'b0);
    check("stray_gap_busy", busy, 1'b1);
    step();
    check("stray_gap_end", busy, 1'b0);
    check("stray_gap_rsp2", rsp_valid, 1'b0);

    // Contention: both valid straight out of reset, three jobs each
    AES_rst = 1'b1;
    step();
    AES_rst = 1'b0;
    j0 = 0; j1 = 0; nr = 0; guard = 0;
    pend0 = 1'b0; pend1 = 1'b0;
    while (nr < 6 && guard < 2000) begin
      if (pend0) j0++;
      if (pend1) j1++;
      req0_valid = (j0 < 3); req0_data = (j0 < 3) ? d0[j0] : '0; req0_key = CKEY;
      req1_valid = (j1 < 3); req1_data = (j1 < 3) ? d1[j1] : '0; req1_key = CKEY;
      #1;
      if (rsp_valid) begin
        exp_id = nr[0];
        exp_d  = exp_id ? (d1[nr / 2] ^ CKEY) : (d0[nr / 2] ^ CKEY);
        check($sformatf("cont_id_%0d", nr), rsp_id, exp_id);
        check($sformatf("cont_data_%0d", nr), rsp_data, exp_d);
        nr++;
      end
      pend0 = req0_ready;
      pend1 = req1_ready;
      guard++;
      @(negedge AES_clk);
    end
    check("cont_rsp_count", nr, 6);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", nmis);
    $fatal(1);
  end

endmodule

// File: doc/aes_req_scheduler.md
Name: aes_req_scheduler

Overview:
- Two-requester round-robin scheduler that shares one AES_top encryption core.
- Accepts plaintext/key jobs over valid/ready, latches them, and drives the core's AES_en/AES_data_in/AES_key_in.
- Holds AES_en high until the core raises AES_data_out_valid, then returns the result tagged with the requester ID.
- A watchdog aborts jobs the core never completes. A mandatory idle gap drops AES_en low between jobs so the core restarts cleanly.

Parameters:
- TIMEOUT_CYCLES, 64: maximum RUN cycles before abort. Legal range 2..255.
- GAP_CYCLES, 2: cycles with core_en low between jobs. Legal range 1..15.

Ports:
- AES_clk  in  1  clock; all logic on rising edge.
- AES_rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 job valid.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req0_data  in  128  requester 0 plaintext.
- req0_key  in  128  requester 0 key.
- req1_valid  in  1  requester 1 job valid.
- req1_ready  out  1  requester 1 job accepted this cycle.
- req1_data  in  128  requester 1 plaintext.
- req1_key  in  128  requester 1 key.
- core_en  out  1  to AES_top AES_en.
- core_data_in  out  128  to AES_top AES_data_in.
- core_key_in  out  128  to AES_top AES_key_in.
- core_data_out  in  128  from AES_top AES_data_out.
- core_data_out_valid  in  1  from AES_top AES_data_out_valid.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  1  requester that owns the result.
- rsp_data  out  128  ciphertext; 0 on timeout.
- rsp_timeout  out  1  job aborted by watchdog.
- busy  out  1  high in any state other than IDLE.

Behaviour:

Reset (AES_rst high, asynchronous; applies at any time, including mid-job):
- State goes to IDLE.
- All outputs go to 0; core_data_in, core_key_in, rsp_data and rsp_id are cleared.
- Priority pointer is set so requester 0 wins first.
- Counters are cleared. An in-flight job is dropped and produces no response.

FSM states: IDLE, RUN, RESP, GAP.

IDLE:
- Grant goes to the single requester with valid high.
- If both are valid, grant goes to the requester the pointer favours.
- reqN_ready is combinational: high only in IDLE, and only for the granted requester.
- The handshake completes on a clock edge where valid and ready are both high. On that edge:
  - latch data and key into core_data_in and core_key_in;
  - latch the grant into rsp_id;
  - flip the pointer to favour the other requester;
  - clear the cycle counter;
  - go to RUN.
- Request inputs may change freely after the accept edge.

RUN:
- core_en is high; it first goes high on the cycle after the accept edge (accept edge T, core_en high from T+1).
- core_data_in and core_key_in stay stable for the whole RUN.
- The counter increments every RUN cycle.
- If core_data_out_valid is high: capture core_data_out into rsp_data, set rsp_timeout=0, go to RESP.
- Else, if the counter equals TIMEOUT_CYCLES-1: set rsp_data=0, rsp_timeout=1, go to RESP.
- If valid and the timeout occur in the same cycle, valid wins.

RESP:
- core_en is 0 and rsp_valid is 1.
- rsp_data, rsp_id and rsp_timeout stay stable until rsp_valid and rsp_ready are both high at a clock edge; then go to GAP with rsp_valid=0.
- rsp_ready may be held high, giving a single-cycle RESP.

GAP:
- core_en stays 0 for exactly GAP_CYCLES cycles, then go to IDLE.
- No request is accepted during GAP.

Core outputs outside RUN:
- core_data_out_valid is ignored outside RUN; late or stray pulses are never reported.

Fairness:
- With both requesters continuously valid, grants alternate 0,1,0,1...
- Best-case job-to-job spacing is RUN length + 1 (RESP) + GAP_CYCLES + 1 (IDLE).

Test Plan:
- Single job, FIPS-197 vector. req0 with key 000102030405060708090a0b0c0d0e0f and data 00112233445566778899aabbccddeeff. Required: req0_ready high for 1 cycle; core_en high from the next cycle until valid; rsp_valid with rsp_id=0, rsp_timeout=0, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Contention. req0 and req1 both valid from the first cycle after reset, each with 3 jobs (key aa2bdb40bff6a5e8caa9ba3ebc1e2acc; data 00000024...0 and a6f2daeb140fa720529e75d521cbc681). Required: response IDs 0,1,0,1,0,1; each rsp_data equals the standalone AES_top result for that job.
- Backpressure. rsp_ready held low for 20 cycles after rsp_valid. Required: rsp_valid, rsp_data and rsp_id stable for all 20 cycles; no new req_ready; core_en=0 throughout.
- Timeout. Stub core with valid tied to 0, TIMEOUT_CYCLES=64. Required: rsp_valid exactly 64 cycles after core_en rises; rsp_timeout=1; rsp_data=0; then core_en low for GAP_CYCLES cycles before the next grant.
- Reset mid-RUN. Assert AES_rst 10 cycles into RUN. Required: core_en, busy and rsp_valid are 0 immediately, without waiting for a clock edge. After release, no response arrives for the dropped job, and requester 0 wins the next contention.
- Stray valid. Pulse core_data_out_valid during IDLE and during GAP. Required: no rsp_valid and no state change.
